pc_sequencer: RTL
=================

# pc_sequencer

Next-PC controller for the pipelined CPU's fetch stage. Holds the program counter and advances it by 4 each cycle. Applies redirects resolved in ID (taken branch, j/jal, jr/jalr) using sign-extend, shift-left-2 and add target arithmetic. Honors hazard-unit stalls and buffers a redirect that arrives while fetch is stalled. Drives the IF/ID squash signal.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- DELAY_SLOT, 1, 1 = branch delay slot architected (no squash); 0 = squash wrong-path fetch

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC this cycle
- br_taken  in  1  ID branch resolved taken
- br_pc4  in  32  PC+4 of the control instruction in ID
- br_imm  in  16  branch offset field
- j_en  in  1  ID holds j/jal
- j_index  in  26  jump index field
- jr_en  in  1  ID holds jr/jalr
- jr_target  in  32  forwarded rs value
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4 (combinational)
- flush_if  out  1  IF/ID holds wrong-path instruction this cycle
- redirect_pending  out  1  buffered redirect waiting on stall release
- misalign_err  out  1  one-cycle pulse: jr_target[1:0] != 0

## Operation
- Request valid = jr_en | j_en | br_taken. Priority is jr > j > branch; lower-priority requests in the same cycle are dropped.
- Targets, all mod 2^32:
  - branch = br_pc4 + ({{14{br_imm[15]}}, br_imm, 2'b00})
  - jump = {br_pc4[31:28], j_index, 2'b00}
  - jr = {jr_target[31:2], 2'b00}
- The pending register holds a 32-bit pend_target and the state bit.
- FSM with 2 states, RUN and PEND:
  - RUN, stall=0, request: pc <= target.
  - RUN, stall=0, no request: pc <= pc+4.
  - RUN, stall=1, request: pc holds; pend_target <= target; go to PEND.
  - RUN, stall=1, no request: pc holds.
  - PEND, stall=1: pc holds. A new request overwrites pend_target (latest wins).
  - PEND, stall=0, request: pc <= new target; pending discarded; go to RUN.
  - PEND, stall=0, no request: pc <= pend_target; go to RUN.
- redirect_pending = (state == PEND).
- flush_if is registered. It is 1 for exactly the cycle after an edge at which pc was loaded from a redirect, and only when DELAY_SLOT=0. With DELAY_SLOT=1 it is tied 0.
- misalign_err is registered. It pulses when an accepted or buffered jr has jr_target[1:0] != 0. The target is still used with its low bits forced to 00.

## Timing
- Reset values: pc=RESET_PC, state=RUN, pend_target=0, flush_if=0, misalign_err=0, redirect_pending=0.
- Reset has priority over everything. Reset mid-PEND discards the buffered target.
- Redirect latency: request sampled at edge E with stall=0 → pc equals target in the cycle after E.
- Stalled redirect: applied at the first edge with stall=0. pc shows it one cycle later.
- The PC+4 wrap 0xFFFF_FFFC → 0x0000_0000 is silent.
- A negative branch offset wraps per two's complement.

## Structure
- Shared package cpu_pkg holds:
  - RESET_PC default
  - state encoding localparams (ST_RUN=1'b0, ST_PEND=1'b1)
  - redirect-select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR)
- Sub-module branch_target_calc is combinational: br_pc4, br_imm, j_index, jr_target and the select → target.
- The FSM and registers live in pc_sequencer.

## Test plan
- Reset, then 3 cycles with no request → pc = 0x3000, 0x3004, 0x3008, 0x300C. All status outputs stay 0.
- br_taken, br_pc4=0x3010, br_imm=0xFFFC, stall=0 → next pc = 0x3000. With DELAY_SLOT=0, flush_if=1 for one cycle.
- j_en=1 and br_taken=1 together, br_pc4=0x3010, j_index=0x0000C10 → pc = 0x3040 (jump wins).
- jr_en, jr_target=0x0000_4006 → pc = 0x4004; misalign_err is a single-cycle pulse.
- Branch pulse to 0x3100 with stall=1 for 3 cycles:
  - During the stall: pc holds and redirect_pending=1.
  - When stall drops: pc = 0x3100 one cycle later and redirect_pending returns to 0.
- In PEND, assert reset → pc=0x3000, redirect_pending=0, and the buffered target is never applied.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage next-PC controller: reset vector,
// sequencer states and redirect-select encoding.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the ID stage / hazard unit (master) and the
// next-PC sequencer (slave).
interface pc_sequencer_if;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_pc4;
   logic [15:0] br_imm;
   logic        j_en;
   logic [25:0] j_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush_if;
   logic        redirect_pending;
   logic        misalign_err;

   modport master (
      output stall, br_taken, br_pc4, br_imm, j_en, j_index, jr_en, jr_target,
      input  pc, pc_plus4, flush_if, redirect_pending, misalign_err
   );

   modport slave (
      input  stall, br_taken, br_pc4, br_imm, j_en, j_index, jr_en, jr_target,
      output pc, pc_plus4, flush_if, redirect_pending, misalign_err
   );
endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// Combinational redirect target: branch offset add, jump region splice, or
// register target with the byte-offset bits cleared.
module branch_target_calc
   import cpu_pkg::*;
(
   input  sel_e        sel_i,
   input  logic [31:0] br_pc4_i,
   input  logic [15:0] br_imm_i,
   input  logic [25:0] j_index_i,
   input  logic [31:0] jr_target_i,
   output logic [31:0] target_o
);

   logic [31:0] br_off;

   assign br_off = {{14{br_imm_i[15]}}, br_imm_i, 2'b00};

   always_comb begin
      target_o = 32'h0000_0000;
      unique case (sel_i)
         SEL_BR:  target_o = br_pc4_i + br_off;
         SEL_J:   target_o = {br_pc4_i[31:28], j_index_i, 2'b00};
         SEL_JR:  target_o = jr_target_i & 32'hFFFF_FFFC;
         default: target_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance, ID-resolved redirects, and
// a one-deep buffer for a redirect that arrives while fetch is stalled.
//
//   state   | meaning
//   ST_RUN  | no redirect buffered; pc advances or redirects when not stalled
//   ST_PEND | redirect buffered in pend_target_q, waiting for stall release
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic           clk_i,
   input  logic           reset_i,
   pc_sequencer_if.slave  bus
);

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_target_q;
   logic        flush_q;
   logic        misalign_q;

   sel_e        sel;
   logic        req;
   logic [31:0] target;

   always_comb begin
      sel = SEL_SEQ;
      if (bus.jr_en)         sel = SEL_JR;
      else if (bus.j_en)     sel = SEL_J;
      else if (bus.br_taken) sel = SEL_BR;
   end

   assign req = (sel != SEL_SEQ);

   branch_target_calc u_calc (
      .sel_i       (sel),
      .br_pc4_i    (bus.br_pc4),
      .br_imm_i    (bus.br_imm),
      .j_index_i   (bus.j_index),
      .jr_target_i (bus.jr_target),
      .target_o    (target)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'h0000_0000;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         flush_q    <= 1'b0;
         // jr always wins arbitration, so every jr is either taken or buffered
         misalign_q <= bus.jr_en & (bus.jr_target[1:0] != 2'b00);
         unique case (state_q)
            ST_RUN: begin
               if (!bus.stall) begin
                  if (req) begin
                     pc_q    <= target;
                     flush_q <= ~DELAY_SLOT;
                  end else begin
                     pc_q <= pc_q + 32'd4;
                  end
               end else if (req) begin
                  pend_target_q <= target;
                  state_q       <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (bus.stall) begin
                  if (req) pend_target_q <= target;
               end else begin
                  pc_q    <= req ? target : pend_target_q;
                  flush_q <= ~DELAY_SLOT;
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.pc               = pc_q;
   assign bus.pc_plus4         = pc_q + 32'd4;
   assign bus.flush_if         = flush_q;
   assign bus.redirect_pending = (state_q == ST_PEND);
   assign bus.misalign_err     = misalign_q;

endmodule
